// File: rtl/prog_result_checker_if.sv
// Bus bundle between a stimulus/sequencer (master) and prog_result_checker (slave):
// arm request, programmed stop/expected values, processor taps and the result outputs.
interface prog_result_checker_if;
  logic        start;
  logic [63:0] stop_pc;
  logic [63:0] expected;
  logic [63:0] currentpc;
  logic [63:0] MemtoRegOut;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [63:0] captured;
  logic [15:0] cycles;
  logic [7:0]  run_count;
  logic [7:0]  pass_count;

  modport master (
    output start, stop_pc, expected, currentpc, MemtoRegOut,
    input  busy, done, pass, timeout, captured, cycles, run_count, pass_count
  );

  modport slave (
    input  start, stop_pc, expected, currentpc, MemtoRegOut,
    output busy, done, pass, timeout, captured, cycles, run_count, pass_count
  );
endinterface

// File: rtl/prog_result_checker.sv
// Self-check stage behind the single-cycle core: waits for PC >= stop address, then grades
// MemtoRegOut against the expected value, with a watchdog. CHECKER_TRACE_EN adds sim-only traces.
module prog_result_checker #(
  parameter logic [15:0] WATCHDOG_MAX = 16'h00FF
) (
  input  logic                 CLK,
  input  logic                 reset,
  prog_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] stop_pc_q, stop_pc_d;
  logic [63:0] expected_q, expected_d;
  logic [63:0] captured_q, captured_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] cycles_q, cycles_d;
  logic [7:0]  run_count_q, run_count_d;
  logic [7:0]  pass_count_q, pass_count_d;
  logic [15:0] cycles_inc_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

  // Next-state and result computation; busy/done are derived from the next state so they stay registered.
  always_comb begin
    state_d      = state_q;
    stop_pc_d    = stop_pc_q;
    expected_d   = expected_q;
    captured_d   = captured_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    cycles_d     = cycles_q;
    run_count_d  = run_count_q;
    pass_count_d = pass_count_q;
    cycles_inc_s = cycles_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          stop_pc_d  = bus.stop_pc;
          expected_d = bus.expected;
          captured_d = 64'd0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          cycles_d   = 16'd0;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cycles_d = cycles_inc_s;
        // A PC match on the same edge as watchdog expiry still counts as a graded run.
        if (bus.currentpc >= stop_pc_q) begin
          captured_d = bus.MemtoRegOut;
          pass_d     = (bus.MemtoRegOut == expected_q);
          state_d    = ST_REPORT;
        end else if (cycles_inc_s == WATCHDOG_MAX) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = ST_REPORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REPORT: begin
        run_count_d = sat_inc8(run_count_q);
        if (pass_q) begin
          pass_count_d = sat_inc8(pass_count_q);
        end else begin
          pass_count_d = pass_count_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_REPORT);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      stop_pc_q    <= 64'd0;
      expected_q   <= 64'd0;
      captured_q   <= 64'd0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cycles_q     <= 16'd0;
      run_count_q  <= 8'd0;
      pass_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      stop_pc_q    <= stop_pc_d;
      expected_q   <= expected_d;
      captured_q   <= captured_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cycles_q     <= cycles_d;
      run_count_q  <= run_count_d;
      pass_count_q <= pass_count_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = timeout_q;
  assign bus.captured   = captured_q;
  assign bus.cycles     = cycles_q;
  assign bus.run_count  = run_count_q;
  assign bus.pass_count = pass_count_q;

`ifdef CHECKER_TRACE_EN
  // Simulation trace of the PC while running and of each verdict.
  always_ff @(posedge CLK) begin
    if (!reset && state_q == ST_RUN) begin
      $display("CurrentPC:%h", bus.currentpc);
    end
    if (!reset && state_q == ST_REPORT) begin
      $display("checker result: %s captured=%h expected=%h cycles=%0d",
               timeout_q ? "timeout" : (pass_q ? "pass" : "fail"),
               captured_q, expected_q, cycles_q);
    end
  end
`endif

endmodule

// File: tb/tb_prog_result_checker.sv
// Bench for prog_result_checker: three instances (watchdog 255, 16, 4) share one randomized
// stimulus stream and are graded against a run-level behavioural model plus fixed scenario values.
module tb_prog_result_checker;

  logic        CLK = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [63:0] stop_i = 64'd0;
  logic [63:0] exp_i = 64'd0;
  logic [63:0] pc_i = 64'd0;
  logic [63:0] mem_i = 64'd0;

  logic        busy_o [3];
  logic        done_o [3];
  logic        pass_o [3];
  logic        to_o   [3];
  logic [63:0] cap_o  [3];
  logic [15:0] cyc_o  [3];
  logic [7:0]  run_o  [3];
  logic [7:0]  pcnt_o [3];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int wd [3] = '{255, 16, 4};

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prog_result_checker_if bus_if ();
    assign bus_if.start       = start_i;
    assign bus_if.stop_pc     = stop_i;
    assign bus_if.expected    = exp_i;
    assign bus_if.currentpc   = pc_i;
    assign bus_if.MemtoRegOut = mem_i;
    assign busy_o[g] = bus_if.busy;
    assign done_o[g] = bus_if.done;
    assign pass_o[g] = bus_if.pass;
    assign to_o[g]   = bus_if.timeout;
    assign cap_o[g]  = bus_if.captured;
    assign cyc_o[g]  = bus_if.cycles;
    assign run_o[g]  = bus_if.run_count;
    assign pcnt_o[g] = bus_if.pass_count;
    prog_result_checker #(
      .WATCHDOG_MAX((g == 0) ? 16'd255 : ((g == 1) ? 16'd16 : 16'd4))
    ) u_dut (
      .CLK   (CLK),
      .reset (reset_i),
      .bus   (bus_if)
    );
  end

  // Reference: each instance is idle, running, or showing its one-cycle verdict.
  int          m_phase  [3];
  logic [63:0] m_stop   [3];
  logic [63:0] m_exp    [3];
  logic [63:0] m_cap    [3];
  logic        m_pass   [3];
  logic        m_to     [3];
  int          m_cyc    [3];
  int          m_runs   [3];
  int          m_passes [3];
  int          done_edge [3];
  int          done_cnt  [3];

  always @(posedge CLK) begin
    edge_n <= edge_n + 1;
    for (int i = 0; i < 3; i++) begin
      if (done_o[i] === 1'b1) begin
        done_edge[i] <= edge_n;
        done_cnt[i]  <= done_cnt[i] + 1;
      end
      if (reset_i) begin
        m_phase[i] <= 0; m_stop[i] <= 64'd0; m_exp[i] <= 64'd0; m_cap[i] <= 64'd0;
        m_pass[i] <= 1'b0; m_to[i] <= 1'b0; m_cyc[i] <= 0; m_runs[i] <= 0; m_passes[i] <= 0;
      end else if (m_phase[i] == 0) begin
        if (start_i) begin
          m_stop[i] <= stop_i; m_exp[i] <= exp_i; m_cap[i] <= 64'd0;
          m_pass[i] <= 1'b0; m_to[i] <= 1'b0; m_cyc[i] <= 0; m_phase[i] <= 1;
        end
      end else if (m_phase[i] == 1) begin
        m_cyc[i] <= m_cyc[i] + 1;
        if (pc_i >= m_stop[i]) begin
          m_cap[i] <= mem_i; m_pass[i] <= (mem_i == m_exp[i]); m_phase[i] <= 2;
        end else if (m_cyc[i] + 1 == wd[i]) begin
          m_to[i] <= 1'b1; m_pass[i] <= 1'b0; m_phase[i] <= 2;
        end
      end else begin
        m_runs[i] <= (m_runs[i] < 255) ? m_runs[i] + 1 : 255;
        if (m_pass[i]) m_passes[i] <= (m_passes[i] < 255) ? m_passes[i] + 1 : 255;
        m_phase[i] <= 0;
      end
    end
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Entered and left at a falling edge; e returns the index of the edge that sampled start.
  task automatic run_prog(input logic [63:0] stop, input logic [63:0] exp, input logic [63:0] pc0,
                          input logic [63:0] step, input logic [63:0] hit, input int n,
                          input int glitch_k, input int reset_k, output int e);
    start_i = 1'b1; stop_i = stop; exp_i = exp; pc_i = pc0; mem_i = rand64(); reset_i = 1'b0;
    @(negedge CLK);
    e = edge_n;
    for (int k = 1; k <= n; k++) begin
      start_i = (k == glitch_k);
      stop_i  = rand64();
      exp_i   = rand64();
      pc_i    = pc0 + step * 64'(k - 1);
      mem_i   = (pc_i >= stop) ? hit : rand64();
      reset_i = (k == reset_k);
      @(negedge CLK);
    end
    start_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic test_reset();
    start_i = 1'b1; stop_i = rand64(); exp_i = rand64(); pc_i = rand64(); mem_i = rand64();
    reset_i = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !== 100'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b pass=%b to=%b cap=%h cyc=%0d runs=%0d passes=%0d, want all 0",
                 i, busy_o[i], done_o[i], pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]);
      end
    end
    reset_i = 1'b0; start_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b, want 0", busy_o[0]);
    end
  endtask

  task automatic test_program1();
    int e, d0;
    d0 = done_cnt[0];
    run_prog(64'h30, 64'hF, 64'd0, 64'd4, 64'hF, 15, 0, 0, e);
    checks++;
    if (done_edge[0] !== e + 13 || done_cnt[0] - d0 !== 1) begin
      errors++;
      $display("FAIL prog1_done: got edge=%0d pulses=%0d, want edge=%0d pulses=1", done_edge[0] - e, done_cnt[0] - d0, 13);
    end
    checks++;
    if ({pass_o[0], to_o[0], cap_o[0], cyc_o[0], run_o[0], pcnt_o[0]} !== {1'b1, 1'b0, 64'hF, 16'd13, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL prog1_result: got pass=%b to=%b cap=%h cyc=%0d runs=%0d passes=%0d, want 1 0 f 13 1 1",
               pass_o[0], to_o[0], cap_o[0], cyc_o[0], run_o[0], pcnt_o[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !==
          {m_phase[i] != 0, m_phase[i] == 2, m_pass[i], m_to[i], m_cap[i], 16'(m_cyc[i]), 8'(m_runs[i]), 8'(m_passes[i])}) begin
        errors++;
        $display("FAIL prog1_model[%0d]: got pass=%b to=%b cap=%h cyc=%0d runs=%0d, want pass=%b to=%b cap=%h cyc=%0d runs=%0d",
                 i, pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], m_pass[i], m_to[i], m_cap[i], m_cyc[i], m_runs[i]);
      end
    end
  endtask

  task automatic test_fail();
    int e;
    logic [7:0] p0;
    p0 = pcnt_o[0];
    run_prog(64'h30, 64'hF, 64'd0, 64'd4, 64'hE, 15, 0, 0, e);
    checks++;
    if ({pass_o[0], to_o[0], cap_o[0], pcnt_o[0]} !== {1'b0, 1'b0, 64'hE, p0}) begin
      errors++;
      $display("FAIL fail_result: got pass=%b to=%b cap=%h passes=%0d, want 0 0 e %0d", pass_o[0], to_o[0], cap_o[0], pcnt_o[0], p0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !==
          {m_pass[i], m_to[i], m_cap[i], 16'(m_cyc[i]), 8'(m_runs[i]), 8'(m_passes[i])}) begin
        errors++;
        $display("FAIL fail_model[%0d]: got pass=%b to=%b cap=%h cyc=%0d runs=%0d, want pass=%b to=%b cap=%h cyc=%0d runs=%0d",
                 i, pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], m_pass[i], m_to[i], m_cap[i], m_cyc[i], m_runs[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    int e;
    run_prog(64'h5C, rand64(), 64'h10, 64'd0, rand64(), 258, 0, 0, e);
    checks++;
    if (done_edge[1] !== e + 16) begin
      errors++;
      $display("FAIL wd16_done: got edge=%0d, want 16", done_edge[1] - e);
    end
    checks++;
    if ({to_o[1], pass_o[1], cyc_o[1], cap_o[1]} !== {1'b1, 1'b0, 16'd16, 64'd0}) begin
      errors++;
      $display("FAIL wd16_result: got to=%b pass=%b cyc=%0d cap=%h, want 1 0 16 0", to_o[1], pass_o[1], cyc_o[1], cap_o[1]);
    end
    checks++;
    if ({to_o[0], cyc_o[0], done_edge[0]} !== {1'b1, 16'd255, e + 255}) begin
      errors++;
      $display("FAIL wd255_result: got to=%b cyc=%0d edge=%0d, want 1 255 255", to_o[0], cyc_o[0], done_edge[0] - e);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !==
          {m_pass[i], m_to[i], m_cap[i], 16'(m_cyc[i]), 8'(m_runs[i]), 8'(m_passes[i])}) begin
        errors++;
        $display("FAIL wd_model[%0d]: got to=%b cyc=%0d runs=%0d, want to=%b cyc=%0d runs=%0d",
                 i, to_o[i], cyc_o[i], run_o[i], m_to[i], m_cyc[i], m_runs[i]);
      end
    end
  endtask

  task automatic test_match_beats_watchdog();
    int e;
    run_prog(64'hC, 64'h123456789ABCDEF0, 64'd0, 64'd4, 64'h123456789ABCDEF0, 6, 0, 0, e);
    checks++;
    if ({pass_o[2], to_o[2], cyc_o[2], cap_o[2], done_edge[2]} !== {1'b1, 1'b0, 16'd4, 64'h123456789ABCDEF0, e + 4}) begin
      errors++;
      $display("FAIL match_beats_wd: got pass=%b to=%b cyc=%0d cap=%h edge=%0d, want 1 0 4 123456789abcdef0 4",
               pass_o[2], to_o[2], cyc_o[2], cap_o[2], done_edge[2] - e);
    end
  endtask

  task automatic test_reset_midrun();
    int e, r0;
    run_prog(64'h30, 64'hF, 64'd0, 64'd4, 64'hF, 4, 0, 3, e);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !== 100'd0) begin
        errors++;
        $display("FAIL midrun_reset[%0d]: got busy=%b cyc=%0d runs=%0d passes=%0d, want all 0",
                 i, busy_o[i], cyc_o[i], run_o[i], pcnt_o[i]);
      end
    end
    r0 = done_cnt[0];
    run_prog(64'h30, 64'hF, 64'd0, 64'd4, 64'hF, 15, 2, 0, e);
    checks++;
    if ({pass_o[0], cap_o[0], cyc_o[0], run_o[0], pcnt_o[0]} !== {1'b1, 64'hF, 16'd13, 8'd1, 8'd1} ||
        done_edge[0] !== e + 13 || done_cnt[0] - r0 !== 1) begin
      errors++;
      $display("FAIL ignored_start: got pass=%b cap=%h cyc=%0d runs=%0d edge=%0d, want 1 f 13 1 13",
               pass_o[0], cap_o[0], cyc_o[0], run_o[0], done_edge[0] - e);
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    reset_i = 1'b1;
    @(negedge CLK);
    reset_i = 1'b0;
    run_prog(64'h30, 64'hF, 64'd0, 64'd4, 64'hF, 14, 14, 0, e1);
    run_prog(64'h5C, 64'h123456789ABCDEF0, 64'd0, 64'd4, 64'h123456789ABCDEF0, 26, 0, 0, e2);
    checks++;
    if ({run_o[0], pcnt_o[0], cap_o[0], done_edge[0]} !== {8'd2, 8'd2, 64'h123456789ABCDEF0, e2 + 24}) begin
      errors++;
      $display("FAIL back_to_back: got runs=%0d passes=%0d cap=%h edge=%0d, want 2 2 123456789abcdef0 24",
               run_o[0], pcnt_o[0], cap_o[0], done_edge[0] - e2);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_o[i], pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !==
          {m_phase[i] != 0, m_pass[i], m_to[i], m_cap[i], 16'(m_cyc[i]), 8'(m_runs[i]), 8'(m_passes[i])}) begin
        errors++;
        $display("FAIL b2b_model[%0d]: got busy=%b pass=%b cyc=%0d runs=%0d, want busy=%b pass=%b cyc=%0d runs=%0d",
                 i, busy_o[i], pass_o[i], cyc_o[i], run_o[i], m_phase[i] != 0, m_pass[i], m_cyc[i], m_runs[i]);
      end
    end
  endtask

  task automatic test_random();
    int e;
    logic [63:0] stop, exp, hit;
    for (int it = 0; it < 6; it++) begin
      stop = 64'($urandom_range(0, 200));
      exp  = rand64();
      hit  = ($urandom_range(0, 1) == 0) ? exp : rand64();
      run_prog(stop, exp, 64'($urandom_range(0, 100)), 64'($urandom_range(0, 6)), hit, 280,
               int'($urandom_range(0, 20)), 0, e);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({busy_o[i], done_o[i], pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i]} !==
            {m_phase[i] != 0, m_phase[i] == 2, m_pass[i], m_to[i], m_cap[i], 16'(m_cyc[i]), 8'(m_runs[i]), 8'(m_passes[i])}) begin
          errors++;
          $display("FAIL random_model[%0d] it%0d: got pass=%b to=%b cap=%h cyc=%0d runs=%0d passes=%0d, want pass=%b to=%b cap=%h cyc=%0d runs=%0d passes=%0d",
                   i, it, pass_o[i], to_o[i], cap_o[i], cyc_o[i], run_o[i], pcnt_o[i],
                   m_pass[i], m_to[i], m_cap[i], m_cyc[i], m_runs[i], m_passes[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int e;
    logic [63:0] v;
    for (int r = 0; r < 260; r++) begin
      v = rand64();
      run_prog(64'd0, v, rand64(), 64'd1, v, 2, 0, 0, e);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({run_o[i], pcnt_o[i]} !== {8'd255, 8'd255}) begin
        errors++;
        $display("FAIL saturation[%0d]: got runs=%0d passes=%0d, want 255 255", i, run_o[i], pcnt_o[i]);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_program1();
    test_fail();
    test_watchdog();
    test_match_beats_watchdog();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
